timer_sched: RTL

//  Multi-channel timeout scheduler around one shared free-running prescaler.
//  - Prescaler produces a one-cycle tick every PRESCALE+1 clocks.
//  - NUM_CH independent down-counters consume that tick; each is one-shot or periodic.
//  - Channel expiries are serialized onto one valid/ready event port by a round-robin arbiter.
//  - Sits between CSR logic (config writes) and a consumer of timeout events.

---
 rtl/timer_sched_pkg.sv | 21 ++
 rtl/timer_sched_rr_pick.sv | 27 ++
 rtl/timer_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and width helpers for the multi-channel timeout scheduler.
package timer_sched_pkg;

  // Widest supported channel counter; narrower loads are zero-extended into it.
  localparam int CW_MAX = 32;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [CW_MAX-1:0] load;
    logic              periodic;
  } ch_cfg_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timer_sched_rr_pick.sv
// Round-robin find-first: first set bit of pending at or above ptr, wrapping.
module timer_sched_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CHW    = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CHW-1:0]    ptr,
  output logic              found,
  output logic [CHW-1:0]    index
);

  always_comb begin
    int j;
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && pending[CHW'(j)]) begin
        found = 1'b1;
        index = CHW'(j);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Multi-channel timeout scheduler: shared prescaler, per-channel down-counters,
// and a round-robin arbiter serializing expiries onto one valid/ready port.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int PRESCALE = 999,
  parameter int NUM_CH   = 4,
  parameter int CW       = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0] i_cfg_ch,
  input  logic                      i_cfg_start,
  input  logic                      i_cfg_periodic,
  input  logic [CW-1:0]             i_cfg_load,
  output logic                      o_evt_valid,
  output logic [$clog2(NUM_CH)-1:0] o_evt_ch,
  input  logic                      i_evt_ready,
  output logic [NUM_CH-1:0]         o_active,
  output logic [NUM_CH-1:0]         o_pending,
  output logic [NUM_CH-1:0]         o_overrun,
  output logic                      ow_tick
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int PW  = clog2_min1(PRESCALE + 1);

  logic [PW-1:0]  pre_cnt_reg;
  logic           evt_valid_reg;
  logic [CHW-1:0] evt_ch_reg;
  logic [CHW-1:0] rr_ptr_reg;
  logic           found;
  logic [CHW-1:0] pick_idx;
  logic           load_out;

  assign ow_tick = (pre_cnt_reg == PW'(PRESCALE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pre_cnt_reg <= '0;
    else          pre_cnt_reg <= ow_tick ? '0 : pre_cnt_reg + 1'b1;
  end

  timer_sched_rr_pick #(
    .NUM_CH (NUM_CH),
    .CHW    (CHW)
  ) u_rr_pick (
    .pending (o_pending),
    .ptr     (rr_ptr_reg),
    .found   (found),
    .index   (pick_idx)
  );

  assign load_out = (!evt_valid_reg || i_evt_ready) && found;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_e         state_reg, state_next;
    ch_cfg_t           cfg_reg, cfg_next;
    logic [CW_MAX-1:0] cnt_reg, cnt_next;
    logic              pend_reg, pend_next;
    logic              ovr_reg, ovr_next;
    logic              cfg_hit;
    logic              expire;

    assign cfg_hit = i_cfg_wr && (i_cfg_ch == CHW'(gi));
    // A config write to this channel swallows a coincident tick.
    assign expire  = ow_tick && !cfg_hit && (state_reg == CH_RUN) && (cnt_reg == '0);

    always_comb begin
      state_next = state_reg;
      cfg_next   = cfg_reg;
      cnt_next   = cnt_reg;
      pend_next  = pend_reg;
      ovr_next   = ovr_reg;
      if (cfg_hit) begin
        pend_next = 1'b0;
        ovr_next  = 1'b0;
        if (i_cfg_start) begin
          state_next        = CH_RUN;
          cnt_next          = CW_MAX'(i_cfg_load);
          cfg_next.load     = CW_MAX'(i_cfg_load);
          cfg_next.periodic = i_cfg_periodic;
        end else begin
          state_next = CH_IDLE;
        end
      end else begin
        if (ow_tick && (state_reg == CH_RUN)) begin
          if (cnt_reg != '0)     cnt_next   = cnt_reg - 1'b1;
          else if (cfg_reg.periodic) cnt_next = cfg_reg.load;
          else                   state_next = CH_IDLE;
        end
        // A fresh expiry outranks the arbiter clearing this bit.
        if (expire) begin
          pend_next = 1'b1;
          if (pend_reg) ovr_next = 1'b1;
        end else if (load_out && (pick_idx == CHW'(gi))) begin
          pend_next = 1'b0;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_reg <= CH_IDLE;
        cfg_reg   <= '0;
        cnt_reg   <= '0;
        pend_reg  <= 1'b0;
        ovr_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cfg_reg   <= cfg_next;
        cnt_reg   <= cnt_next;
        pend_reg  <= pend_next;
        ovr_reg   <= ovr_next;
      end
    end

    assign o_active[gi]  = (state_reg == CH_RUN);
    assign o_pending[gi] = pend_reg;
    assign o_overrun[gi] = ovr_reg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_valid_reg <= 1'b0;
      evt_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else if (load_out) begin
      evt_valid_reg <= 1'b1;
      evt_ch_reg    <= pick_idx;
      rr_ptr_reg    <= (pick_idx == CHW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
    end else if (i_evt_ready) begin
      evt_valid_reg <= 1'b0;
    end
  end

  assign o_evt_valid = evt_valid_reg;
  assign o_evt_ch    = evt_ch_reg;

endmodule
